// File: rtl/vga_char_pkg.sv
// Shared types for the character-output sink: FSM states, the reserved
// clear-screen position code and the capture FIFO entry layout.
// No ports; imported by vga_char_fifo users and the vga_char_sink top.
package vga_char_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [15:0] CLEAR_POS = 16'hFFFF;

  typedef struct packed {
    logic [15:0] pos;
    logic [15:0] chr;
  } fifo_entry_t;

endpackage

// File: rtl/vga_char_sink_if.sv
// Screen RAM write port: valid/ready handshake carrying address and data.
// master: scr_valid/scr_addr/scr_data out, scr_ready in. slave: the reverse.
// A write completes on any cycle where scr_valid and scr_ready are both high.
interface vga_char_sink_if;
  logic        scr_valid;
  logic        scr_ready;
  logic [15:0] scr_addr;
  logic [15:0] scr_data;

  modport master (output scr_valid, output scr_addr, output scr_data, input scr_ready);
  modport slave  (input scr_valid, input scr_addr, input scr_data, output scr_ready);
endinterface

// File: rtl/vga_char_fifo.sv
// Synchronous first-word-fall-through FIFO, DEPTH entries (power of two, >= 2).
// Latency: a push is visible on dout the next cycle; dout is combinational from storage.
// Backpressure: push is ignored when full unless a pop frees the slot in the same cycle.
// Ports: wire_clock, wire_reset (sync, active-high), push/din, pop, full, empty, dout.
module vga_char_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             wire_clock,
  input  logic             wire_reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB on each pointer separates full (MSBs differ) from empty (equal).
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge wire_clock) begin
    if (wire_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge wire_clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/vga_char_sink.sv
// Captures cpu_v character strobes (falling edge of videoflag) into a FIFO and
// drains them to screen RAM; position 16'hFFFF sweeps BLANK_CHAR over the screen.
// Latency: capture at N -> scr_valid at N+2; holds scr_valid/addr/data until scr_ready.
// Ports: wire_clock, wire_reset (sync, active-high), videoflag, bus_vga_pos, bus_vga_char,
//   scr (screen RAM write port, master), busy, overflow (sticky), range_err (1-cycle pulse).
// Build option VGA_CHAR_COLOR_EN: keep character bits 15:8 (colour); otherwise they are zeroed.
module vga_char_sink
  import vga_char_pkg::*;
#(
  parameter int          COLS       = 40,
  parameter int          ROWS       = 30,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] BLANK_CHAR = 16'h0020
) (
  input  logic             wire_clock,
  input  logic             wire_reset,
  input  logic             videoflag,
  input  logic [15:0]      bus_vga_pos,
  input  logic [15:0]      bus_vga_char,
  vga_char_sink_if.master  scr,
  output logic             busy,
  output logic             overflow,
  output logic             range_err
);
  localparam logic [15:0] SCREEN_SIZE = 16'(COLS * ROWS);
  localparam logic [15:0] LAST_POS    = SCREEN_SIZE - 16'd1;

  state_t      state;
  logic        vf_q;
  logic        capture;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  fifo_entry_t cap_entry;
  fifo_entry_t head;
  logic [15:0] head_word;
  logic [15:0] blank_word;

  assign capture   = vf_q && !videoflag;
  assign cap_entry = '{pos: bus_vga_pos, chr: bus_vga_char};
  assign pop       = (state == IDLE) && !fifo_empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push      = capture && (!fifo_full || pop);

`ifdef VGA_CHAR_COLOR_EN
  assign head_word  = head.chr;
  assign blank_word = BLANK_CHAR;
`else
  assign head_word  = head.chr & 16'h00FF;
  assign blank_word = BLANK_CHAR & 16'h00FF;
`endif

  assign busy = !fifo_empty || scr.scr_valid || (state != IDLE);

  vga_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .wire_clock (wire_clock),
    .wire_reset (wire_reset),
    .push       (push),
    .din        (cap_entry),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .dout       (head)
  );

  always_ff @(posedge wire_clock) begin
    if (wire_reset) begin
      state         <= IDLE;
      vf_q          <= 1'b0;
      overflow      <= 1'b0;
      range_err     <= 1'b0;
      scr.scr_valid <= 1'b0;
      scr.scr_addr  <= 16'h0000;
      scr.scr_data  <= 16'h0000;
    end else begin
      vf_q      <= videoflag;
      range_err <= 1'b0;
      if (capture && fifo_full && !pop) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (head.pos == CLEAR_POS) begin
              scr.scr_addr  <= 16'h0000;
              scr.scr_data  <= blank_word;
              scr.scr_valid <= 1'b1;
              state         <= CLEAR;
            end else if (head.pos < SCREEN_SIZE) begin
              scr.scr_addr  <= head.pos;
              scr.scr_data  <= head_word;
              scr.scr_valid <= 1'b1;
              state         <= WRITE;
            end else begin
              range_err <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (scr.scr_ready) begin
            scr.scr_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        CLEAR: begin
          if (scr.scr_ready) begin
            if (scr.scr_addr == LAST_POS) begin
              scr.scr_valid <= 1'b0;
              state         <= IDLE;
            end else begin
              scr.scr_addr <= scr.scr_addr + 16'd1;
            end
          end
        end
        default: begin
          scr.scr_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vga_char_sink.sv
// Directed bench for vga_char_sink: a vector table of single strobes plus
// hand-written sequences for strobe ordering, overflow, clear and reset-in-clear.
module tb_vga_char_sink;
  logic        clk = 1'b0;
  logic        rst;
  logic        videoflag;
  logic [15:0] pos;
  logic [15:0] chr;
  logic        busy;
  logic        overflow;
  logic        range_err;

  vga_char_sink_if scr_if();

  vga_char_sink dut (
    .wire_clock   (clk),
    .wire_reset   (rst),
    .videoflag    (videoflag),
    .bus_vga_pos  (pos),
    .bus_vga_char (chr),
    .scr          (scr_if),
    .busy         (busy),
    .overflow     (overflow),
    .range_err    (range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } hs_t;

  hs_t hs_q[$];
  int  rerr_cnt = 0;
  int  n_checks = 0;
  int  n_fail   = 0;

  // Handshakes and range_err pulses observed half a cycle before the edge that acts on them.
  always @(negedge clk) begin
    if (!rst) begin
      if (scr_if.scr_valid && scr_if.scr_ready) hs_q.push_back('{scr_if.scr_addr, scr_if.scr_data});
      if (range_err) rerr_cnt++;
    end
  end

  function automatic logic [15:0] exp_word(input logic [15:0] w);
`ifdef VGA_CHAR_COLOR_EN
    return w;
`else
    return {8'h00, w[7:0]};
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] p, input logic [15:0] c);
    pos       = p;
    chr       = c;
    videoflag = 1'b1;
    tick();
    videoflag = 1'b0;
  endtask

  typedef struct {
    logic [15:0] pos;
    logic [15:0] chr;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;
    int          exp_lat;
    int          exp_hs;
    int          exp_re;
  } vec_t;

  localparam int NV = 5;
  vec_t vec[NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int base_re;
    int lat;
    int n;
    int bad;
    int gap;
    bit done;
    bit found;

    vec[0] = '{16'h0205, 16'h0041, 16'h0205, exp_word(16'h0041), 2, 1, 0};
    vec[1] = '{16'h0000, 16'hAB42, 16'h0000, exp_word(16'hAB42), 2, 1, 0};
    vec[2] = '{16'd1200, 16'h0055, 16'h0000, 16'h0000,           0, 0, 1};
    vec[3] = '{16'd1199, 16'h007A, 16'd1199, exp_word(16'h007A), 2, 1, 0};
    vec[4] = '{16'hFFFE, 16'h0033, 16'h0000, 16'h0000,           0, 0, 1};

    rst = 1'b1;
    videoflag = 1'b0;
    pos = 16'h0000;
    chr = 16'h0000;
    scr_if.scr_ready = 1'b0;
    repeat (3) tick();
    check("reset_valid",    {31'd0, scr_if.scr_valid}, 32'd0);
    check("reset_addr",     {16'd0, scr_if.scr_addr},  32'd0);
    check("reset_data",     {16'd0, scr_if.scr_data},  32'd0);
    check("reset_busy",     {31'd0, busy},             32'd0);
    check("reset_overflow", {31'd0, overflow},         32'd0);
    check("reset_rangeerr", {31'd0, range_err},        32'd0);
    rst = 1'b0;
    tick();

    // Table of single one-cycle strobes with scr_ready tied high.
    scr_if.scr_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      base    = hs_q.size();
      base_re = rerr_cnt;
      strobe(vec[i].pos, vec[i].chr);
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
        tick();
        if (scr_if.scr_valid && lat == 0) lat = k;
      end
      check($sformatf("vec%0d_latency", i), lat, vec[i].exp_lat);
      check($sformatf("vec%0d_hs_count", i), hs_q.size() - base, vec[i].exp_hs);
      if (hs_q.size() > base) begin
        check($sformatf("vec%0d_addr", i), {16'd0, hs_q[base].a}, {16'd0, vec[i].exp_addr});
        check($sformatf("vec%0d_data", i), {16'd0, hs_q[base].d}, {16'd0, vec[i].exp_data});
      end
      check($sformatf("vec%0d_range_err", i), rerr_cnt - base_re, vec[i].exp_re);
      check($sformatf("vec%0d_busy_idle", i), {31'd0, busy}, 32'd0);
    end

    // Flag raised first, data changes while the flag is high.
    base = hs_q.size();
    pos = 16'h7777;
    chr = 16'h0000;
    videoflag = 1'b1;
    tick();
    pos = 16'h0010;
    chr = 16'h0121;
    tick();
    videoflag = 1'b0;
    repeat (8) tick();
    check("flagfirst_hs_count", hs_q.size() - base, 1);
    if (hs_q.size() > base) begin
      check("flagfirst_addr", {16'd0, hs_q[base].a}, 32'h0010);
      check("flagfirst_data", {16'd0, hs_q[base].d}, {16'd0, exp_word(16'h0121)});
    end

    // Backpressure: one entry on the port, four in the FIFO, sixth dropped.
    scr_if.scr_ready = 1'b0;
    base = hs_q.size();
    for (int i = 0; i < 6; i++) begin
      strobe(16'd100 + 16'(i), 16'h0130 + 16'(i));
      tick();
    end
    repeat (2) tick();
    check("bp_overflow", {31'd0, overflow}, 32'd1);
    check("bp_valid_held", {31'd0, scr_if.scr_valid}, 32'd1);
    check("bp_addr_held", {16'd0, scr_if.scr_addr}, 32'd100);
    check("bp_no_hs", hs_q.size() - base, 0);
    check("bp_busy", {31'd0, busy}, 32'd1);
    scr_if.scr_ready = 1'b1;
    repeat (20) tick();
    check("bp_hs_count", hs_q.size() - base, 5);
    if (hs_q.size() >= base + 5) begin
      for (int j = 0; j < 5; j++) begin
        check($sformatf("bp_addr%0d", j), {16'd0, hs_q[base+j].a}, 32'd100 + j);
        check($sformatf("bp_data%0d", j), {16'd0, hs_q[base+j].d}, {16'd0, exp_word(16'h0130 + 16'(j))});
      end
    end
    check("bp_overflow_sticky", {31'd0, overflow}, 32'd1);
    check("bp_busy_idle", {31'd0, busy}, 32'd0);

    // Full clear sweep.
    base = hs_q.size();
    gap  = 0;
    done = 1'b0;
    strobe(16'hFFFF, 16'h0000);
    for (int k = 0; k < 3000 && !done; k++) begin
      tick();
      if (hs_q.size() - base >= 1200) done = 1'b1;
      else if (hs_q.size() > base && !busy) gap++;
    end
    check("clear_complete", {31'd0, done}, 32'd1);
    check("clear_busy_gaps", gap, 0);
    repeat (4) tick();
    check("clear_hs_count", hs_q.size() - base, 1200);
    bad = 0;
    for (int j = 0; j < 1200 && base + j < hs_q.size(); j++) begin
      if (hs_q[base+j].a !== 16'(j) || hs_q[base+j].d !== exp_word(16'h0020)) bad++;
    end
    check("clear_contents_bad", bad, 0);
    check("clear_valid_idle", {31'd0, scr_if.scr_valid}, 32'd0);
    check("clear_busy_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of a clear sweep.
    found = 1'b0;
    strobe(16'hFFFF, 16'h0000);
    for (int k = 0; k < 2000 && !found; k++) begin
      tick();
      if (scr_if.scr_valid && scr_if.scr_addr == 16'd500) found = 1'b1;
    end
    check("rstclr_reached_500", {31'd0, found}, 32'd1);
    check("rstclr_ovf_before", {31'd0, overflow}, 32'd1);
    rst = 1'b1;
    tick();
    check("rstclr_valid", {31'd0, scr_if.scr_valid}, 32'd0);
    check("rstclr_busy", {31'd0, busy}, 32'd0);
    check("rstclr_overflow", {31'd0, overflow}, 32'd0);
    check("rstclr_range_err", {31'd0, range_err}, 32'd0);
    rst = 1'b0;
    n = hs_q.size();
    repeat (20) tick();
    check("rstclr_no_more_writes", hs_q.size() - n, 0);
    check("rstclr_valid_after", {31'd0, scr_if.scr_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_char_sink.md
Name: vga_char_sink

Overview:
- Responder end of the processor's character-output interface (videoflag / bus_vga_pos / bus_vga_char).
- Captures each character-write strobe issued by cpu_v and buffers it in a small FIFO.
- Drains the FIFO into the text-mode screen RAM write port through a valid/ready handshake.
- Also runs a clear-screen sweep on a reserved position code.
- Sits between cpu_v and the VGA text controller's screen memory.

Parameters:
- COLS, 40, characters per row.
- ROWS, 30, rows per screen; valid positions are 0..COLS*ROWS-1.
- FIFO_DEPTH, 4, capture FIFO entries; power of two, at least 2.
- BLANK_CHAR, 16'h0020, word written by the clear-screen sweep.

Ports:
- wire_clock  in  1  system clock; all logic on posedge.
- wire_reset  in  1  synchronous, active-high reset.
- videoflag  in  1  write strobe from cpu_v.
- bus_vga_pos  in  16  screen position from cpu_v.
- bus_vga_char  in  16  character word from cpu_v.
- scr_valid  out  1  screen RAM write request.
- scr_ready  in  1  screen RAM accepts the write when high together with scr_valid.
- scr_addr  out  16  screen RAM address.
- scr_data  out  16  screen RAM data.
- busy  out  1  high while the FIFO is non-empty, a write is pending, or a clear is running.
- overflow  out  1  sticky; a capture was dropped because the FIFO was full.
- range_err  out  1  one-cycle pulse when a capture is discarded as out of range.

Behaviour:
- Reset is synchronous and active-high; no asynchronous reset.
  - All outputs reset to 0. FIFO is emptied, FSM goes to IDLE, vf_q clears to 0.
  - Reset mid-write or mid-clear aborts it immediately; any partial clear is not resumed.
- Capture:
  - vf_q is videoflag registered.
  - A capture event is vf_q==1 && videoflag==0, i.e. the falling edge of the strobe.
  - On that cycle, bus_vga_pos and bus_vga_char are sampled. cpu_v holds both stable through the cycle after videoflag drops, whichever order it sets the flag and the data.
  - Strobes of any high length, including one cycle, yield exactly one capture.
  - If the FIFO is full on a capture event, the entry is dropped and overflow is set; it clears only on reset.
  - A push and a pop in the same cycle while the FIFO is full is not full-dropped: the pop frees the slot.
- Classification happens at pop time:
  - pos==16'hFFFF: clear command.
  - pos < COLS*ROWS: normal write.
  - Otherwise: discarded, range_err pulses for 1 cycle, and nothing reaches the RAM.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop. A normal entry loads scr_addr/scr_data, sets scr_valid and goes to WRITE. A clear entry sets scr_addr=0, scr_data=BLANK_CHAR, scr_valid=1 and goes to CLEAR. An out-of-range entry stays in IDLE.
  - WRITE: hold scr_valid, scr_addr and scr_data stable until scr_ready. On the handshake, drop scr_valid and return to IDLE.
  - CLEAR: on each handshake, scr_addr increments. On the handshake at COLS*ROWS-1, drop scr_valid and return to IDLE.
  - Captures keep filling the FIFO during WRITE and CLEAR.
- Latency: capture at cycle N → entry in FIFO at N+1 → scr_valid high at N+2 (empty FIFO, IDLE). Back-to-back writes with scr_ready tied high sustain 1 write per 2 cycles.
- Arithmetic:
  - FIFO pointers wrap modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.
  - COLS*ROWS is computed as a 16-bit constant.
  - The clear counter is 16-bit and never wraps past COLS*ROWS-1.
- scr_data is bus_vga_char, subject to the optional feature below.

Optional Feature:
- Macro: VGA_CHAR_COLOR_EN.
- Defined: scr_data = bus_vga_char unmodified; bits 15:8 carry the colour attribute.
- Undefined: scr_data = {8'h00, bus_vga_char[7:0]}, and BLANK_CHAR[15:8] is likewise forced to 0.

Decomposition:
- Shared package vga_char_pkg holds:
  - the FSM state enum {IDLE, WRITE, CLEAR};
  - the localparam CLEAR_POS = 16'hFFFF;
  - the FIFO entry struct {pos[15:0], chr[15:0]}.
- One sub-module, vga_char_fifo: synchronous FIFO parameterised by FIFO_DEPTH, with push, pop, full, empty and dout.
- The capture edge detector and the FSM live in the top.

Test Plan:
- Single write: videoflag high 1 cycle with pos=16'h0205, char=16'h0041, scr_ready=1 → exactly one handshake, addr=16'h0205, data=16'h0041, scr_valid first high 2 cycles after videoflag falls.
- Flag-first ordering: raise videoflag, change pos to 16'h0010 and char to 16'h0121 the next cycle, drop flag → one write with addr=16'h0010, data=16'h0121.
- Backpressure and overflow: scr_ready=0, issue 6 strobes with FIFO_DEPTH=4 → the first entry is held on the port, 4 entries sit in the FIFO, the 6th is dropped and overflow=1. Then scr_ready=1 → exactly 5 writes in capture order.
- Range check: pos=16'd1200 → range_err pulses once, no scr_valid. Next pos=16'd1199 is written normally.
- Clear: pos=16'hFFFF, scr_ready=1 → 1200 writes of 16'h0020 to addresses 0..1199, busy high throughout, then IDLE.
- Reset during clear: assert wire_reset at address 500 → next cycle scr_valid=0, busy=0, overflow=0, and no further writes.
